// File: rtl/addsub_byte_seq.sv
// Byte-serial add/subtract unit. A single SLICE-bit adder is reused over
// NSLICE cycles to form a WIDTH-bit a+b or a-b, with carry-out and signed
// overflow. Control is a start/busy/done handshake; results are registered
// and hold until the next accepted start.
module addsub_byte_seq #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             add_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             carry,
   output logic             overflow
);

   localparam int NSLICE = WIDTH / SLICE;
   localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01
   } state_e;

   state_e           state_q, state_d;
   logic [KW-1:0]    k_q, k_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] bx_q, bx_d;
   logic             c_q, c_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic             carry_q, carry_d;
   logic             ovf_q, ovf_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [SLICE:0]   slice_sum;
   logic             last_slice;

   // Shared slice adder: current slice of A plus current slice of B' plus the running carry
   always_comb begin
      slice_sum = {1'b0, a_q[k_q*SLICE +: SLICE]}
                + {1'b0, bx_q[k_q*SLICE +: SLICE]}
                + {{SLICE{1'b0}}, c_q};
   end

   assign last_slice = (k_q == K_LAST);

   // State register
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic: IDLE -> RUN on start, RUN -> IDLE after the last slice
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)      state_d = RUN;
         RUN:     if (last_slice) state_d = IDLE;
         default:                 state_d = IDLE;
      endcase
   end

   // Datapath and output next-values for each state
   always_comb begin
      k_d     = k_q;
      a_d     = a_q;
      bx_d    = bx_q;
      c_d     = c_q;
      s_d     = s_q;
      carry_d = carry_q;
      ovf_d   = ovf_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               // Subtraction is a + ~b + 1: invert B here and seed the carry with add_sub.
               a_d     = a;
               bx_d    = b ^ {WIDTH{add_sub}};
               c_d     = add_sub;
               k_d     = '0;
               s_d     = '0;
               carry_d = 1'b0;
               ovf_d   = 1'b0;
               busy_d  = 1'b1;
            end
         end
         RUN: begin
            c_d                     = slice_sum[SLICE];
            s_d[k_q*SLICE +: SLICE] = slice_sum[SLICE-1:0];
            k_d                     = k_q + 1'b1;
            if (last_slice) begin
               k_d     = '0;
               carry_d = slice_sum[SLICE];
               // The top slice's MSB is the result sign bit.
               ovf_d   = (a_q[WIDTH-1] == bx_q[WIDTH-1]) &&
                         (slice_sum[SLICE-1] != a_q[WIDTH-1]);
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         default: begin
            busy_d = 1'b0;
         end
      endcase
   end

   // Datapath and output registers
   // NOTE: operand registers are reset too, so an aborted operation leaves no residue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_q     <= '0;
         a_q     <= '0;
         bx_q    <= '0;
         c_q     <= 1'b0;
         s_q     <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         k_q     <= k_d;
         a_q     <= a_d;
         bx_q    <= bx_d;
         c_q     <= c_d;
         s_q     <= s_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign s        = s_q;
   assign carry    = carry_q;
   assign overflow = ovf_q;

endmodule
